// File: rtl/mem_access_unit.sv
// Data-memory load/store sequencer: one bus transaction per start, registered outputs.
// Optional build macro MISALIGN_TRAP_EN turns misaligned H/W accesses into an immediate error completion.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic [31:0] ld_ir,
  output logic [1:0]  ld_offset
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        busy_nxt, done_nxt, err_nxt, mem_req_nxt, mem_we_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt, ld_data_nxt, ld_ir_nxt;
  logic [3:0]  mem_be_nxt;
  logic [1:0]  ld_offset_nxt;
  logic [2:0]  funct3;
  logic        is_store;
  logic        misaligned;

  assign funct3   = ir[14:12];
  assign is_store = (ir[6:0] == 7'b0100011);

  always_comb begin
    misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (funct3[1:0] == 2'b01)
      misaligned = addr[0];
    else if (funct3 == 3'b010)
      misaligned = |addr[1:0];
`endif
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_be_nxt    = mem_be;
    mem_wdata_nxt = mem_wdata;
    ld_data_nxt   = ld_data;
    ld_ir_nxt     = ld_ir;
    ld_offset_nxt = ld_offset;

    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt      = 16'd0;
          ld_ir_nxt    = ir;
          mem_addr_nxt = {addr[31:2], 2'b00};
          mem_we_nxt   = is_store;
          case (funct3[1:0])
            2'b00:   ld_offset_nxt = addr[1:0];
            2'b01:   ld_offset_nxt = {1'b0, addr[1]};
            default: ld_offset_nxt = 2'b00;
          endcase
          if (!is_store) begin
            mem_be_nxt    = 4'b1111;
            mem_wdata_nxt = 32'd0;
          end else begin
            case (funct3)
              3'b000: begin
                mem_be_nxt    = 4'b0001 << addr[1:0];
                mem_wdata_nxt = {4{wdata[7:0]}};
              end
              3'b001: begin
                mem_be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata_nxt = {2{wdata[15:0]}};
              end
              default: begin
                mem_be_nxt    = 4'b1111;
                mem_wdata_nxt = wdata;
              end
            endcase
          end
          if (misaligned) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            state_nxt   = REQ;
            mem_req_nxt = 1'b1;
          end
        end
      end
      REQ: begin
        // Ack wins over a timeout landing on the same edge.
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          if (!mem_we) ld_data_nxt = mem_rdata;
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          mem_req_nxt = 1'b0;
          state_nxt   = DONE;
          done_nxt    = 1'b1;
          err_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      ld_data   <= 32'd0;
      ld_ir     <= 32'd0;
      ld_offset <= 2'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_be    <= mem_be_nxt;
      mem_wdata <= mem_wdata_nxt;
      ld_data   <= ld_data_nxt;
      ld_ir     <= ld_ir_nxt;
      ld_offset <= ld_offset_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus requests and completions, a monitor checks them.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0, addr = '0, wdata = '0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ld_data, ld_ir;
  logic [1:0]  ld_offset;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int req_len = 0, last_req_len = 0;
  int busy_len = 0, last_busy_len = 0;
  logic req_prev = 1'b0, busy_prev = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } req_exp_t;

  typedef struct {
    logic        e;
    logic [31:0] data;
    logic [31:0] irx;
    logic [1:0]  off;
    logic        chk_off;
    int          lat;
  } done_exp_t;

  req_exp_t  req_q[$];
  done_exp_t done_q[$];

  mem_access_unit #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .start(start), .ir(ir), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_data(ld_data), .ld_ir(ld_ir), .ld_offset(ld_offset)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares bus requests and completions against the scoreboard queues.
  always @(negedge clock) begin
    req_exp_t  r;
    done_exp_t d;
    if (mem_req && !req_prev) begin
      if (req_q.size() == 0) begin
        check("unexpected_req", 32'(mem_req), 32'd0);
      end else begin
        r = req_q.pop_front();
        check("req_addr", mem_addr, r.a);
        check("req_be", 32'(mem_be), 32'(r.be));
        check("req_wdata", mem_wdata, r.wd);
        check("req_we", 32'(mem_we), 32'(r.we));
      end
    end
    if (mem_req) req_len++;
    else if (req_prev) begin last_req_len = req_len; req_len = 0; end
    if (busy) busy_len++;
    else if (busy_prev) begin last_busy_len = busy_len; busy_len = 0; end
    req_prev  = mem_req;
    busy_prev = busy;
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        d = done_q.pop_front();
        check("done_err", 32'(err), 32'(d.e));
        check("ld_data", ld_data, d.data);
        check("ld_ir", ld_ir, d.irx);
        if (d.chk_off) check("ld_offset", 32'(ld_offset), 32'(d.off));
        if (d.lat >= 0) check("done_latency", 32'(cyc - start_cyc), 32'(d.lat));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] w);
    ir = i; addr = a; wdata = w; start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic ack_after(input int n, input logic [31:0] rd);
    repeat (n) tick();
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0BAD0BAD;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 50) begin tick(); k++; end
    if (busy) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    tick();
  endtask

  task automatic push_req(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic we);
    req_exp_t r;
    r.a = a; r.be = be; r.wd = wd; r.we = we;
    req_q.push_back(r);
  endtask

  task automatic push_done(input logic e, input logic [31:0] data, input logic [31:0] irx,
                           input logic [1:0] off, input logic chk_off, input int lat);
    done_exp_t d;
    d.e = e; d.data = data; d.irx = irx; d.off = off; d.chk_off = chk_off; d.lat = lat;
    done_q.push_back(d);
  endtask

  initial begin
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err_req_we", {28'd0, done, err, mem_req, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_be_off", {26'd0, mem_be, ld_offset}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ld", ld_data | ld_ir, 32'd0);
    reset = 1'b1;
    tick();

    // LW with ack on the fourth request cycle
    push_req(32'h100, 4'b1111, 32'h0, 1'b0);
    push_done(1'b0, 32'hDEADBEEF, 32'h00002003, 2'd0, 1'b1, 4);
    issue(32'h00002003, 32'h100, 32'h0);
    ack_after(3, 32'hDEADBEEF);
    wait_idle("lw");
    check("lw_busy_len", 32'(last_busy_len), 32'd5);

    // LB / LH immediate ack
    push_req(32'h200, 4'b1111, 32'h0, 1'b0);
    push_done(1'b0, 32'h11223344, 32'h00000003, 2'd3, 1'b1, 1);
    issue(32'h00000003, 32'h203, 32'h0);
    ack_after(0, 32'h11223344);
    wait_idle("lb");
    push_req(32'h200, 4'b1111, 32'h0, 1'b0);
    push_done(1'b0, 32'h99887766, 32'h00001003, 2'd1, 1'b1, 1);
    issue(32'h00001003, 32'h202, 32'h0);
    ack_after(0, 32'h99887766);
    wait_idle("lh");

    // Stores leave ld_data alone
    push_req(32'h40, 4'b0010, 32'hABABABAB, 1'b1);
    push_done(1'b0, 32'h99887766, 32'h00000023, 2'd0, 1'b0, 1);
    issue(32'h00000023, 32'h41, 32'h123456AB);
    ack_after(0, 32'hFFFFFFFF);
    wait_idle("sb");
    push_req(32'h40, 4'b1100, 32'h12341234, 1'b1);
    push_done(1'b0, 32'h99887766, 32'h00001023, 2'd0, 1'b0, 1);
    issue(32'h00001023, 32'h42, 32'hCAFE1234);
    ack_after(0, 32'hFFFFFFFF);
    wait_idle("sh");

    // Timeout with a stray start during REQ
    push_req(32'h300, 4'b1111, 32'h0, 1'b0);
    push_done(1'b1, 32'h99887766, 32'h00002003, 2'd0, 1'b1, 8);
    issue(32'h00002003, 32'h300, 32'h0);
    tick(); tick();
    ir = 32'h00000023; addr = 32'h500; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("timeout");
    repeat (4) tick();
    check("timeout_req_len", 32'(last_req_len), 32'd8);
    check("timeout_no_requeue", {30'd0, busy, mem_req}, 32'd0);

    // Reset in the middle of REQ
    push_req(32'h400, 4'b1111, 32'h0, 1'b0);
    issue(32'h00002003, 32'h400, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_req_busy_done", {29'd0, mem_req, busy, done}, 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_ld", ld_data | ld_ir, 32'd0);
    tick();
    push_req(32'h104, 4'b1111, 32'h0, 1'b0);
    push_done(1'b0, 32'h55AA55AA, 32'h00002003, 2'd0, 1'b1, 1);
    issue(32'h00002003, 32'h104, 32'h0);
    ack_after(0, 32'h55AA55AA);
    wait_idle("post_rst");

    // Misaligned LW
`ifdef MISALIGN_TRAP_EN
    push_done(1'b1, 32'h55AA55AA, 32'h00002003, 2'd0, 1'b1, 0);
    issue(32'h00002003, 32'h102, 32'h0);
    wait_idle("misalign");
`else
    push_req(32'h100, 4'b1111, 32'h0, 1'b0);
    push_done(1'b0, 32'h11112222, 32'h00002003, 2'd0, 1'b1, 1);
    issue(32'h00002003, 32'h102, 32'h0);
    ack_after(0, 32'h11112222);
    wait_idle("misalign");
`endif

    repeat (3) tick();
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
